// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared constants and FSM state type for the fetch stage
package ifu_prefetch_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam int          INSTR_W  = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - PC, instruction memory and decode-side signals of the fetch stage
interface ifu_prefetch_if
   import ifu_prefetch_pkg::*;
#(
   parameter int AW = 32
);
   logic [AW-1:0]      pc;
   logic [AW-1:0]      npc;
   logic               im_req;
   logic [AW-1:0]      im_addr;
   logic               im_rdy;
   logic [INSTR_W-1:0] im_data;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [AW-1:0]      instr_pc;
   logic               dec_ready;
   logic               redirect;
   logic [AW-1:0]      redirect_pc;

   modport master (
      input  pc, im_rdy, im_data, dec_ready, redirect, redirect_pc,
      output npc, im_req, im_addr, instr_valid, instr, instr_pc
   );

   modport slave (
      output pc, im_rdy, im_data, dec_ready, redirect, redirect_pc,
      input  npc, im_req, im_addr, instr_valid, instr, instr_pc
   );
endinterface

// File: rtl/ifu_prefetch_fifo.sv
// rtl/ifu_prefetch_fifo.sv - small pointer FIFO holding {pc, instruction} pairs
module ifu_prefetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 64,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic [CW-1:0] count_o
);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign do_push = push_i && (count_q != FULL);
   assign do_pop  = pop_i && (count_q != '0);

   // Flush wins over push/pop so a redirect always leaves the FIFO empty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
         if (do_push && !do_pop)
            count_q <= count_q + CW'(1);
         else if (!do_push && do_pop)
            count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - fetch stage: issues word fetches, buffers returns, drives NPC
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   ifu_prefetch_if.master bus
);
   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam int          EW      = AW + INSTR_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_e        state_q;
   logic [AW-1:0] reqpc_q;
   logic [CW-1:0] count;
   logic [EW-1:0] dout;
   logic          issue, push, pop;

   // Reset gates issue so no request leaks out while the PC register is still resetting.
   assign issue = !rst_i && (state_q == S_IDLE) && (count < DEPTH_C) && !bus.redirect;
   assign push  = (state_q == S_WAIT) && bus.im_rdy && !bus.redirect;
   assign pop   = bus.instr_valid && bus.dec_ready && !bus.redirect;

   assign bus.im_req  = issue;
   assign bus.im_addr = bus.pc;
   assign bus.npc     = bus.redirect ? bus.redirect_pc :
                        issue        ? bus.pc + AW'(4) : bus.pc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         reqpc_q <= AW'(RESET_PC);
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (issue) begin
                  state_q <= S_WAIT;
                  reqpc_q <= bus.pc;
               end
            end
            S_WAIT: begin
               if (bus.im_rdy)        state_q <= S_IDLE;
               else if (bus.redirect) state_q <= S_DROP;
            end
            S_DROP: begin
               if (bus.im_rdy) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   ifu_prefetch_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.redirect),
      .din_i   ({reqpc_q, bus.im_data}),
      .dout_o  (dout),
      .count_o (count)
   );

   assign bus.instr_valid = (count != '0);
   assign bus.instr_pc    = dout[EW-1:INSTR_W];
   assign bus.instr       = dout[INSTR_W-1:0];
endmodule
